// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and immediate field layouts used by the fetch queue and decode.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } iq_entry_t;

    function automatic logic [31:0] imm_b_field(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j_field(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational B/J immediate extraction, opcode-agnostic; shared with decode.
module imm_extract
    import riscv_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [31:0] imm_b_o,
    output logic [31:0] imm_j_o
);

    assign imm_b_o = imm_b_field(instr_i);
    assign imm_j_o = imm_j_field(instr_i);

endmodule

// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry register FIFO of {pc, instr} with flush.
module instr_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_instr,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_imm_b,
    output logic [31:0]                out_imm_j,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    iq_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push, pop;
    iq_entry_t         head;

    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately unreset; the empty mask below hides stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{pc: in_pc, instr: in_instr};
        end
    end

    always_comb begin
        head = '{pc: 32'h0, instr: NOP_INSTR};
        if (out_valid) head = mem_q[rd_ptr_q];
    end

    assign out_pc    = head.pc;
    assign out_instr = head.instr;
    assign count     = count_q;

    imm_extract u_imm_extract (
        .instr_i (head.instr),
        .imm_b_o (out_imm_b),
        .imm_j_o (out_imm_j)
    );

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: queue-based reference model plus directed literal checks.
module tb_instr_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc, out_instr, out_imm_b, out_imm_j;
    logic [$clog2(DEPTH):0] count;

    int ntests = 0;
    int nfail  = 0;
    bit chk_en = 1'b0;

    logic [63:0] mq[$];

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_imm_b (out_imm_b),
        .out_imm_j (out_imm_j),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_imm_b(input logic [31:0] w);
        int v;
        v = int'((w >> 8) & 32'hF) * 2 + int'((w >> 25) & 32'h3F) * 32 + int'((w >> 7) & 32'h1) * 2048;
        if (w[31]) v = v - 4096;
        return 32'(v);
    endfunction

    function automatic logic [31:0] m_imm_j(input logic [31:0] w);
        int v;
        v = int'((w >> 21) & 32'h3FF) * 2 + int'((w >> 20) & 32'h1) * 2048 + int'((w >> 12) & 32'hFF) * 4096;
        if (w[31]) v = v - (1 << 20);
        return 32'(v);
    endfunction

    // Reference model: occupancy and ordering from a plain queue.
    always @(posedge clk) begin
        bit do_pop, do_push;
        do_pop  = (mq.size() > 0) && out_ready;
        do_push = in_valid && (mq.size() < DEPTH);
        if (reset || flush) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({in_pc, in_instr});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] e_pc, e_instr;
            e_pc    = 32'h0;
            e_instr = 32'h0000_0013;
            if (mq.size() > 0) begin
                e_pc    = mq[0][63:32];
                e_instr = mq[0][31:0];
            end
            chk("m_count", 32'(count), 32'(mq.size()));
            chk("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("m_in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
            chk("m_out_pc", out_pc, e_pc);
            chk("m_out_instr", out_instr, e_instr);
            chk("m_imm_b", out_imm_b, m_imm_b(e_instr));
            chk("m_imm_j", out_imm_j, m_imm_j(e_instr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_out_instr", out_instr, 32'h0000_0013);

        // single push, 1-cycle latency
        in_valid = 1'b1; in_pc = 32'h00; in_instr = 32'h0050_0093;
        step();
        in_valid = 1'b0;
        chk("p1_out_valid", 32'(out_valid), 32'h1);
        chk("p1_out_pc", out_pc, 32'h00);
        chk("p1_count", 32'(count), 32'h1);

        // fill to DEPTH, then a blocked push
        for (int i = 1; i < 4; i++) begin
            in_valid = 1'b1; in_pc = 32'(i * 4); in_instr = 32'h0000_0013 + 32'(i << 7);
            step();
        end
        chk("full_count", 32'(count), 32'h4);
        chk("full_in_ready", 32'(in_ready), 32'h0);
        in_pc = 32'h10; in_instr = 32'hDEAD_BEEF;
        step();
        in_valid = 1'b0;
        chk("blocked_count", 32'(count), 32'h4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", out_pc, 32'(i * 4));
            step();
        end
        chk("drain_count", 32'(count), 32'h0);

        // immediates
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h40; in_instr = 32'hFE00_98E3;
        step();
        chk("bne_imm_b", out_imm_b, 32'hFFFF_FFF0);
        out_ready = 1'b1; in_pc = 32'h44; in_instr = 32'h0080_006F;
        step();
        in_valid = 1'b0;
        chk("jal_imm_j", out_imm_j, 32'h0000_0008);
        chk("jal_count", 32'(count), 32'h1);
        step();
        out_ready = 1'b0;

        // flush dominates push and pop
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_pc = 32'h80 + 32'(i * 4); in_instr = 32'h0010_0093;
            step();
        end
        chk("pre_flush_count", 32'(count), 32'h3);
        flush = 1'b1; in_pc = 32'h8C; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("flush_count", 32'(count), 32'h0);
        chk("flush_out_valid", 32'(out_valid), 32'h0);
        chk("flush_out_instr", out_instr, 32'h0000_0013);

        // streaming across pointer wrap
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_pc = 32'(i * 4); in_instr = 32'h0000_0093 + 32'(i << 20);
            step();
            chk("stream_count", 32'(count), 32'h1);
            chk("stream_pc", out_pc, 32'(i * 4));
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        chk("stream_empty", 32'(count), 32'h0);

        // mid-stream reset
        in_valid = 1'b1;
        in_pc = 32'hA0; step();
        in_pc = 32'hA4; step();
        in_valid = 1'b0;
        chk("pre_rst_count", 32'(count), 32'h2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_count", 32'(count), 32'h0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'h1);
        step();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving the number of queue entries; legal values are powers of two from 2 to 16.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port in_valid, input, 1 bit: the fetch side presents an instruction.
REQ-005 The module SHALL have port in_ready, output, 1 bit: the queue accepts an instruction this cycle.
REQ-006 The module SHALL have port in_pc, input, 32 bits: the address of the presented instruction (fetch current_pc).
REQ-007 The module SHALL have port in_instr, input, 32 bits: the instruction word from instruction memory.
REQ-008 The module SHALL have port flush, input, 1 bit: discard all queued entries (a redirect from jump or taken branch).
REQ-009 The module SHALL have port out_valid, output, 1 bit: the head entry is available to decode.
REQ-010 The module SHALL have port out_ready, input, 1 bit: decode consumes the head entry this cycle.
REQ-011 The module SHALL have port out_pc, output, 32 bits: the head entry PC.
REQ-012 The module SHALL have port out_instr, output, 32 bits: the head entry instruction.
REQ-013 The module SHALL have port out_imm_b, output, 32 bits: the sign-extended B-type immediate of the head entry (drives fetch imm_address).
REQ-014 The module SHALL have port out_imm_j, output, 32 bits: the sign-extended J-type immediate of the head entry (drives fetch imm_address_jump).
REQ-015 The module SHALL have port count, output, $clog2(DEPTH)+1 bits: the number of occupied entries.

Function
REQ-016 The module SHALL drive in_ready = (count < DEPTH), combinationally from registered count, with no dependence on out_ready.
REQ-017 The module SHALL enqueue {in_pc, in_instr} at the write pointer when in_valid && in_ready, then increment the write pointer modulo DEPTH.
REQ-018 The module SHALL drive out_valid = (count != 0) and dequeue when out_valid && out_ready, then increment the read pointer modulo DEPTH.
REQ-019 The module SHALL have no empty-queue bypass: an entry enqueued at edge N is visible at the outputs from edge N onward, giving a 1-cycle minimum latency.
REQ-020 On a simultaneous enqueue and dequeue, count SHALL remain unchanged and both pointers SHALL advance; when full, enqueue SHALL be blocked even if out_ready=1.
REQ-021 When empty, out_pc SHALL be 32'h00000000, out_instr SHALL be NOP 32'h00000013, and out_imm_b and out_imm_j SHALL be 0.
REQ-022 The module SHALL compute out_imm_b = sign-extend{instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
REQ-023 The module SHALL compute out_imm_j = sign-extend{instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
REQ-024 Immediates SHALL be combinational from the head entry, independent of opcode.
REQ-025 When flush=1, at the next edge count, the read pointer and the write pointer SHALL all be 0.
REQ-026 Flush SHALL dominate any same-cycle enqueue or dequeue; the in_valid word presented in the flush cycle SHALL be dropped.
REQ-027 Pointer wrap SHALL be seamless, with no bubble at the DEPTH-1 → 0 transition.
REQ-028 Neither count overflow (count > DEPTH) nor count underflow SHALL be reachable under any input sequence.

Reset
REQ-029 When reset=1 at a rising edge, the module SHALL set count=0, read pointer=0 and write pointer=0.
REQ-030 Reset SHALL override flush, enqueue and dequeue in the same cycle.
REQ-031 The storage array SHALL NOT be reset; outputs SHALL be masked per REQ-021 while empty.
REQ-032 After reset, outputs SHALL be out_valid=0, in_ready=1, count=0, out_instr=32'h00000013.
REQ-033 A reset asserted mid-stream SHALL discard all entries, identically to flush.

Structure
REQ-034 The shared package riscv_pkg SHALL hold the NOP encoding 32'h00000013, the opcode constants (BRANCH 7'b1100011, JAL 7'b1101111), and the imm_b/imm_j bit-field definitions.
REQ-035 Immediate extraction SHALL be a combinational sub-module imm_extract, reused by the decode stage.
REQ-036 Storage SHALL be a DEPTH×64-bit register array {pc, instr}, with no RAM macro.

Verification
REQ-037 The bench SHALL cover: reset, then push pc=0x00 instr=0x00500093 with out_ready=0 → next cycle out_valid=1, out_pc=0x00, count=1.
REQ-038 The bench SHALL cover: push 4 entries with out_ready=0 → count=4, in_ready=0; a 5th push with in_valid=1 is ignored; drain order is pc 0x00, 0x04, 0x08, 0x0C.
REQ-039 The bench SHALL cover: head instr=0xFE0098E3 (bne, -16) → out_imm_b=0xFFFFFFF0; head instr=0x0080006F (jal +8) → out_imm_j=0x00000008.
REQ-040 The bench SHALL cover: count=3, with flush=1, in_valid=1 and out_ready=1 in the same cycle → next cycle count=0, out_valid=0, out_instr=0x00000013.
REQ-041 The bench SHALL cover: continuous push/pop for 10 cycles with out_ready=1 → count steady at 1, PCs out in order 0x00 to 0x24 across pointer wrap, no bubble.
REQ-042 The bench SHALL cover: reset asserted with count=2 and flush=0 → next cycle count=0 and in_ready=1.
